lsu_operand_fetch: RTL and testbench

- Parametrised successor to the LSU's per-RAM operand path: one instance serves one operand RAM (IRAM or WRAM).
- Accepts one conv fetch command and walks a 2-D byte window. Row walk runs up or down the RAM entries; column walk runs forward or reverse inside each entry.
- Emits one lane-aligned, masked vector per row to the MXU over a ready/valid handshake.
- Adds what the first generation lacked: lane-count/depth generality, output backpressure with a skid FIFO, abort, and a done/busy indication.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_byte_align.sv | 34 +++
 rtl/lsu_operand_fetch.sv | 193 +++++++++++++++++++
 tb/tb_lsu_operand_fetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU operand fetch path.
package lsu_pkg;

    localparam int BYTE_W    = 8;
    localparam int LANES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of a lane index / byte offset field for a given lane count.
    // The column-length field is one bit wider so it can hold LANES itself.
    function automatic int lane_idx_w(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/lsu_byte_align.sv
// Rotates one RAM entry so the first window byte lands in lane 0, optionally
// walking the entry backwards, and zeroes/masks lanes beyond the column length.
module lsu_byte_align
    import lsu_pkg::*;
#(
    parameter int LANES = LANES_DEF
) (
    input  logic [LANES*BYTE_W-1:0]      raw,
    input  logic [lane_idx_w(LANES)-1:0] off,
    input  logic [lane_idx_w(LANES):0]   col_len,
    input  logic                         col_dir,
    output logic [LANES*BYTE_W-1:0]      aligned,
    output logic [LANES-1:0]             mask
);

    localparam int IDX_W = lane_idx_w(LANES);

    logic [IDX_W-1:0] src;

    // Per-lane byte select; the IDX_W-bit sum wraps inside the entry.
    always_comb begin
        aligned = '0;
        mask    = '0;
        src     = '0;
        for (int j = 0; j < LANES; j++) begin
            src = col_dir ? (off + IDX_W'(j)) : (off - IDX_W'(j));
            if ((IDX_W + 1)'(j) < col_len) begin
                mask[j]                      = 1'b1;
                aligned[j*BYTE_W +: BYTE_W]  = raw[int'(src)*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/lsu_operand_fetch.sv
// Operand fetch for one LSU operand RAM: walks a 2-D byte window row by row,
// aligns each entry, and streams masked vectors to the MXU through a skid FIFO.
module lsu_operand_fetch
    import lsu_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int ADDR_W     = 8,
    parameter int ROW_W      = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_vld,
    output logic                         cmd_rdy,
    input  logic [ADDR_W-1:0]            cmd_addr,
    input  logic [lane_idx_w(LANES)-1:0] cmd_byte_off,
    input  logic [lane_idx_w(LANES):0]   cmd_col_len,
    input  logic                         cmd_col_dir,
    input  logic [ROW_W-1:0]             cmd_row_cnt,
    input  logic                         cmd_row_dir,
    input  logic                         abort,
    output logic                         mem_cen,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [LANES*BYTE_W-1:0]      mem_dout,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [LANES*BYTE_W-1:0]      out_data,
    output logic [LANES-1:0]             out_mask,
    output logic                         out_last,
    output logic                         busy
);

    localparam int IDX_W  = lane_idx_w(LANES);
    localparam int DATA_W = LANES * BYTE_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    logic [ADDR_W-1:0] row_addr;
    logic [IDX_W-1:0]  off_q;
    logic [IDX_W:0]    len_q;
    logic              col_dir_q;
    logic              row_dir_q;
    logic [ROW_W-1:0]  row_cnt_q;
    logic [ROW_W-1:0]  k;
    logic              inflight;
    logic              inflight_last;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [LANES-1:0]  fifo_mask [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              noop;
    logic              pop;
    logic              push;
    logic              room;
    logic              issue;
    logic              last_row;
    logic [CNT_W:0]    occ_next;
    logic [DATA_W-1:0] push_data;
    logic [LANES-1:0]  push_mask;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign cmd_rdy  = (state == IDLE) && !rst && !abort;
    assign accept   = cmd_vld && cmd_rdy;
    assign noop     = (cmd_col_len == '0) || (cmd_row_cnt == '0);
    assign out_vld  = (count != '0);
    assign pop      = out_vld && out_rdy;
    assign push     = inflight;
    assign busy     = (state != IDLE);
    assign last_row = (k == row_cnt_q - ROW_W'(1));

    // A head leaving this cycle frees its slot before the new read lands,
    // which is what sustains one row per cycle with a two-entry FIFO.
    assign occ_next = {1'b0, count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
    assign room     = occ_next < (CNT_W + 1)'(FIFO_DEPTH);

    // The RAM returns data one cycle after the request, so the read strobe is
    // decoded straight from the current state rather than registered.
    assign issue    = (state == ISSUE) && !abort && room;
    assign mem_cen  = issue;
    assign mem_addr = issue ? row_addr : '0;

    assign out_data = out_vld ? fifo_data[rd_ptr] : '0;
    assign out_mask = out_vld ? fifo_mask[rd_ptr] : '0;
    assign out_last = out_vld && fifo_last[rd_ptr];

    lsu_byte_align #(
        .LANES(LANES)
    ) u_align (
        .raw     (mem_dout),
        .off     (off_q),
        .col_len (len_q),
        .col_dir (col_dir_q),
        .aligned (push_data),
        .mask    (push_mask)
    );

    // Command FSM: latches the command, walks the rows, tracks the read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            row_addr      <= '0;
            off_q         <= '0;
            len_q         <= '0;
            col_dir_q     <= 1'b0;
            row_dir_q     <= 1'b0;
            row_cnt_q     <= '0;
            k             <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else if (abort) begin
            state         <= IDLE;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_last <= last_row;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        row_addr  <= cmd_addr;
                        off_q     <= cmd_byte_off;
                        len_q     <= cmd_col_len;
                        col_dir_q <= cmd_col_dir;
                        row_dir_q <= cmd_row_dir;
                        row_cnt_q <= cmd_row_cnt;
                        k         <= '0;
                        if (!noop) begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        k        <= k + ROW_W'(1);
                        row_addr <= row_dir_q ? (row_addr + ADDR_W'(1))
                                              : (row_addr - ADDR_W'(1));
                        if (last_row) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((count == '0) && !inflight) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; abort discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage; contents are only observed through the occupancy-gated outputs.
    always_ff @(posedge clk) begin
        if (push && !abort) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_mask[wr_ptr] <= push_mask;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

endmodule

// File: tb/tb_lsu_operand_fetch.sv
// Bench for lsu_operand_fetch: a RAM model behind the read port, a monitor that
// records reads and accepted vectors, and a row-by-row reference of the window walk.
module tb_lsu_operand_fetch;

    logic         clk;
    logic         rst;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [7:0]   cmd_addr;
    logic [3:0]   cmd_byte_off;
    logic [4:0]   cmd_col_len;
    logic         cmd_col_dir;
    logic [4:0]   cmd_row_cnt;
    logic         cmd_row_dir;
    logic         abort;
    logic         mem_cen;
    logic [7:0]   mem_addr;
    logic [127:0] mem_dout;
    logic         out_vld;
    logic         out_rdy;
    logic [127:0] out_data;
    logic [15:0]  out_mask;
    logic         out_last;
    logic         busy;

    logic [127:0] ram [256];
    logic [7:0]   rd_q  [$];
    int           rd_cyc[$];
    logic [127:0] od_q  [$];
    logic [15:0]  om_q  [$];
    bit           ol_q  [$];
    int           od_cyc[$];
    int           cyc;
    bit           busy_seen;
    int           rdy_mode;
    int           total;
    int           bad;

    lsu_operand_fetch #(
        .LANES(16), .ADDR_W(8), .ROW_W(5), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr),
        .cmd_byte_off(cmd_byte_off), .cmd_col_len(cmd_col_len),
        .cmd_col_dir(cmd_col_dir), .cmd_row_cnt(cmd_row_cnt),
        .cmd_row_dir(cmd_row_dir), .abort(abort),
        .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .out_mask(out_mask), .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data for a read appears the cycle after the request.
    always @(posedge clk) begin
        if (mem_cen) mem_dout <= ram[mem_addr];
    end

    // Monitor: sample mid-cycle, record reads and completed output handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            cyc = cyc + 1;
            if (busy) busy_seen = 1'b1;
            if (mem_cen) begin
                rd_q.push_back(mem_addr);
                rd_cyc.push_back(cyc);
            end
            if (out_vld && out_rdy) begin
                od_q.push_back(out_data);
                om_q.push_back(out_mask);
                ol_q.push_back(out_last);
                od_cyc.push_back(cyc);
            end
        end
    end

    // MXU ready driver: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = 1'($urandom_range(0, 1));
                default: out_rdy = 1'b0;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: one aligned row of the window straight from the RAM contents.
    function automatic logic [127:0] modelRow(input int a, input int off, input int len, input bit cdir);
        logic [127:0] v;
        logic [127:0] e;
        int idx;
        v = '0;
        e = ram[a];
        for (int j = 0; j < len; j++) begin
            idx = cdir ? (off + j) % 16 : (off - j + 16) % 16;
            v[j*8 +: 8] = e[idx*8 +: 8];
        end
        return v;
    endfunction

    task automatic clearQueues();
        rd_q.delete(); rd_cyc.delete();
        od_q.delete(); om_q.delete(); ol_q.delete(); od_cyc.delete();
        busy_seen = 1'b0;
    endtask

    // Present one command and hold it until the handshake completes.
    task automatic applyStimulus(input int addr, input int off, input int len, input bit cdir,
                                 input int rows, input bit rdir);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        clearQueues();
        cmd_addr     = 8'(addr);
        cmd_byte_off = 4'(off);
        cmd_col_len  = 5'(len);
        cmd_col_dir  = cdir;
        cmd_row_cnt  = 5'(rows);
        cmd_row_dir  = rdir;
        cmd_vld      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = cmd_rdy;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        cmd_vld = 1'b0;
        checkOutput("cmd_accept", 128'(ok), 128'(1));
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy && !out_vld) break;
        end
        checkOutput("idle_reached", 128'(busy | out_vld), 128'(0));
    endtask

    task automatic checkCommand(input string name, input int addr, input int off, input int len,
                                input bit cdir, input int rows, input bit rdir);
        int n;
        int a;
        logic [15:0] m;
        n = (len == 0 || rows == 0) ? 0 : rows;
        m = (len >= 16) ? 16'hFFFF : 16'((1 << len) - 1);
        checkOutput({name, "_nreads"}, 128'(rd_q.size()), 128'(n));
        checkOutput({name, "_nvec"}, 128'(od_q.size()), 128'(n));
        for (int r = 0; r < n; r++) begin
            a = ((addr + (rdir ? r : -r)) % 256 + 256) % 256;
            if (r < rd_q.size())
                checkOutput($sformatf("%s_addr%0d", name, r), 128'(rd_q[r]), 128'(a));
            if (r < od_q.size()) begin
                checkOutput($sformatf("%s_data%0d", name, r), od_q[r], modelRow(a, off, len, cdir));
                checkOutput($sformatf("%s_mask%0d", name, r), 128'(om_q[r]), 128'(m));
                checkOutput($sformatf("%s_last%0d", name, r), 128'(ol_q[r]), 128'(r == n - 1));
            end
        end
    endtask

    initial begin
        int a, o, l, rw;
        bit cd, rd;
        total = 0; bad = 0; cyc = 0; rdy_mode = 0;
        rst = 1'b1; abort = 1'b0; cmd_vld = 1'b0;
        cmd_addr = '0; cmd_byte_off = '0; cmd_col_len = '0; cmd_col_dir = 1'b0;
        cmd_row_cnt = '0; cmd_row_dir = 1'b0; mem_dout = '0;
        for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        clearQueues();

        #3;
        checkOutput("rst_ctrl", 128'({mem_cen, mem_addr, out_vld, out_mask, out_last, busy, cmd_rdy}), 128'(0));
        checkOutput("rst_data", out_data, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic three-row walk at full rate
        applyStimulus(8'h10, 3, 4, 1'b1, 3, 1'b1);
        waitIdle();
        checkCommand("t1", 8'h10, 3, 4, 1'b1, 3, 1'b1);
        checkOutput("t1_mask0", 128'(om_q.size() > 0 ? om_q[0] : 16'h0), 128'(16'h000F));
        if (rd_cyc.size() >= 3 && od_cyc.size() >= 3) begin
            checkOutput("t1_rd_gap1", 128'(rd_cyc[1] - rd_cyc[0]), 128'(1));
            checkOutput("t1_rd_gap2", 128'(rd_cyc[2] - rd_cyc[1]), 128'(1));
            checkOutput("t1_latency", 128'(od_cyc[0] - rd_cyc[0]), 128'(2));
            checkOutput("t1_thruput", 128'(od_cyc[2] - od_cyc[0]), 128'(2));
        end else begin
            checkOutput("t1_stamps", 128'(rd_cyc.size() + od_cyc.size()), 128'(6));
        end

        // Reverse column walk and forward wrap inside one entry
        applyStimulus(8'h40, 14, 4, 1'b0, 1, 1'b1);
        waitIdle();
        checkCommand("t2r", 8'h40, 14, 4, 1'b0, 1, 1'b1);
        checkOutput("t2r_lane3", 128'(od_q.size() > 0 ? od_q[0][31:24] : 8'h0), 128'(ram[8'h40][11*8 +: 8]));
        applyStimulus(8'h40, 14, 4, 1'b1, 1, 1'b1);
        waitIdle();
        checkCommand("t2w", 8'h40, 14, 4, 1'b1, 1, 1'b1);
        checkOutput("t2w_lane2", 128'(od_q.size() > 0 ? od_q[0][23:16] : 8'h0), 128'(ram[8'h40][7:0]));

        // Downward row walk wrapping below address zero
        applyStimulus(8'h00, 0, 16, 1'b1, 2, 1'b0);
        waitIdle();
        checkCommand("t3", 8'h00, 0, 16, 1'b1, 2, 1'b0);
        checkOutput("t3_addr1", 128'(rd_q.size() > 1 ? rd_q[1] : 8'h0), 128'(8'hFF));

        // Stalled consumer: reads stop once the FIFO space is committed
        rdy_mode = 2;
        applyStimulus(8'h80, 5, 9, 1'b0, 6, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("t4_reads_held", 128'(rd_q.size()), 128'(2));
        checkOutput("t4_vld_held", 128'(out_vld), 128'(1));
        rdy_mode = 0;
        waitIdle();
        checkCommand("t4", 8'h80, 5, 9, 1'b0, 6, 1'b1);

        // Abort with one row buffered and one read in flight
        rdy_mode = 2;
        applyStimulus(8'h20, 0, 8, 1'b1, 8, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_q.size() >= 2) break;
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("t5_pre_vld", 128'(out_vld), 128'(1));
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("t5_post", 128'({out_vld, busy, cmd_rdy}), 128'(3'b001));
        rdy_mode = 0;
        repeat (5) @(negedge clk);
        checkOutput("t5_no_vec", 128'(od_q.size()), 128'(0));
        checkOutput("t5_no_read", 128'(rd_q.size()), 128'(2));

        // Abort alongside a command in IDLE blocks acceptance
        @(posedge clk);
        #1;
        clearQueues();
        cmd_addr = 8'h33; cmd_byte_off = 4'd0; cmd_col_len = 5'd4; cmd_row_cnt = 5'd2;
        cmd_vld = 1'b1; abort = 1'b1;
        @(negedge clk);
        checkOutput("t5_cmd_rdy", 128'(cmd_rdy), 128'(0));
        @(posedge clk);
        #1;
        cmd_vld = 1'b0; abort = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_not_taken", 128'({busy_seen, 8'(rd_q.size())}), 128'(0));

        // No-op commands are taken but do nothing
        applyStimulus(8'h55, 2, 0, 1'b1, 4, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("t6_len0", 128'({busy_seen, 8'(rd_q.size()), 8'(od_q.size())}), 128'(0));
        applyStimulus(8'h55, 2, 7, 1'b1, 0, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("t6_rows0", 128'({busy_seen, 8'(rd_q.size()), 8'(od_q.size())}), 128'(0));

        // Reset in the middle of a command
        rdy_mode = 1;
        applyStimulus(8'hC0, 1, 12, 1'b1, 20, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_ctrl", 128'({mem_cen, mem_addr, out_vld, out_mask, out_last, busy, cmd_rdy}), 128'(0));
        checkOutput("t6_rst_data", out_data, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random commands under random backpressure
        for (int t = 0; t < 24; t++) begin
            a  = $urandom_range(0, 255);
            o  = $urandom_range(0, 15);
            l  = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 16);
            rw = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(1, 8);
            cd = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 1);
            applyStimulus(a, o, l, cd, rw, rd);
            waitIdle();
            checkCommand($sformatf("rnd%0d", t), a, o, l, cd, rw, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
